// File: rtl/mem_data_ctrl.sv
// Byte-serial load/store responder: one MEM-stage request becomes little-endian
// accesses on an 8-bit synchronous-read RAM; loads return an extended 32-bit word.
module mem_data_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic                  flush,
  output logic                  busy,
  output logic                  mmem_finished,
  output logic [31:0]           mmem_data,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [7:0]            mem_dout,
  output logic                  mem_wr,
  input  logic [7:0]            mem_din
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t                state_reg;
  logic [1:0]            size_reg;
  logic                  signed_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [31:0]           wdata_reg;
  logic [31:0]           rdata_reg;
  logic [2:0]            idx_reg;   // index of the next byte to put on the bus

  logic                  accept;
  logic [2:0]            n_bytes;
  logic [1:0]            cap_idx;
  logic [ADDR_WIDTH-1:0] next_a;
  logic [7:0]            next_dout;
  logic [31:0]           last_word;
  logic [31:0]           ext_word;

  always_comb begin
    accept = req_valid && !flush && (state_reg == IDLE || state_reg == DONE);
    unique case (size_reg)
      2'b00:   n_bytes = 3'd1;
      2'b01:   n_bytes = 3'd2;
      default: n_bytes = 3'd4;
    endcase
    // RAM data lags its address by one cycle, so captures trail the issue index
    cap_idx   = (state_reg == DRAIN) ? idx_reg[1:0] - 2'd1 : idx_reg[1:0] - 2'd2;
    next_a    = addr_reg + ADDR_WIDTH'(idx_reg);
    next_dout = wdata_reg[{idx_reg[1:0], 3'b000} +: 8];
    last_word = rdata_reg;
    last_word[{cap_idx, 3'b000} +: 8] = mem_din;
    unique case (size_reg)
      2'b00:   ext_word = {{24{signed_reg & last_word[7]}}, last_word[7:0]};
      2'b01:   ext_word = {{16{signed_reg & last_word[15]}}, last_word[15:0]};
      default: ext_word = last_word;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      size_reg      <= 2'b00;
      signed_reg    <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= 32'h0;
      rdata_reg     <= 32'h0;
      idx_reg       <= 3'd0;
      busy          <= 1'b0;
      mmem_finished <= 1'b0;
      mmem_data     <= 32'h0;
      mem_a         <= '0;
      mem_dout      <= 8'h00;
      mem_wr        <= 1'b0;
    end else begin
      mmem_finished <= 1'b0;
      busy          <= 1'b0;
      mem_wr        <= 1'b0;
      mem_a         <= '0;
      mem_dout      <= 8'h00;
      if (accept) begin
        size_reg   <= req_size;
        signed_reg <= req_signed;
        addr_reg   <= req_addr;
        wdata_reg  <= req_wdata;
        idx_reg    <= 3'd1;
        busy       <= 1'b1;
        mem_a      <= req_addr;
        mem_wr     <= req_we;
        mem_dout   <= req_we ? req_wdata[7:0] : 8'h00;
        state_reg  <= req_we ? WRITE : READ;
      end else begin
        unique case (state_reg)
          // flush is deliberately not honoured here: bytes already written stay written
          WRITE: begin
            if (idx_reg == n_bytes) begin
              state_reg     <= DONE;
              mmem_finished <= 1'b1;
            end else begin
              busy     <= 1'b1;
              mem_wr   <= 1'b1;
              mem_a    <= next_a;
              mem_dout <= next_dout;
              idx_reg  <= idx_reg + 3'd1;
            end
          end
          READ: begin
            if (flush) begin
              state_reg <= IDLE;
            end else begin
              busy <= 1'b1;
              if (idx_reg >= 3'd2) rdata_reg[{cap_idx, 3'b000} +: 8] <= mem_din;
              if (idx_reg == n_bytes) begin
                state_reg <= DRAIN;
              end else begin
                mem_a   <= next_a;
                idx_reg <= idx_reg + 3'd1;
              end
            end
          end
          DRAIN: begin
            if (flush) begin
              state_reg <= IDLE;
            end else begin
              rdata_reg     <= last_word;
              mmem_data     <= ext_word;
              mmem_finished <= 1'b1;
              state_reg     <= DONE;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule
